// File: rtl/popcount_pkg.sv
// ============================================================================
// Module      : popcount_pkg
// Description : Shared state encoding, chunk size and width helpers for the
//               iterative population-count unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package popcount_pkg;

    localparam int CHUNK = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic int calc_nchunk(input int width);
        return (width + CHUNK - 1) / CHUNK;
    endfunction

    function automatic int calc_cw(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/counter_3_2.sv
// ============================================================================
// Module      : counter_3_2
// Description : 3:2 counter (full adder) cell.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_3_2 (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (a & c) | (b & c);

endmodule

`default_nettype wire

// File: rtl/counter_7_3.sv
// ============================================================================
// Module      : counter_7_3
// Description : 7:3 counter built from four 3:2 cells; cnt = ones in x.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_7_3 (
    input  logic [6:0] x,
    output logic [2:0] cnt
);

    logic w_s0, w_c0, w_s1, w_c1, w_c2;

    counter_3_2 u_fa0 (.a(x[0]), .b(x[1]), .c(x[2]), .sum(w_s0), .carry(w_c0));
    counter_3_2 u_fa1 (.a(x[3]), .b(x[4]), .c(x[5]), .sum(w_s1), .carry(w_c1));
    counter_3_2 u_fa2 (.a(w_s0), .b(w_s1), .c(x[6]), .sum(cnt[0]), .carry(w_c2));
    // The three weight-2 carries are summed into the weight-2 and weight-4 bits
    counter_3_2 u_fa3 (.a(w_c0), .b(w_c1), .c(w_c2), .sum(cnt[1]), .carry(cnt[2]));

endmodule

`default_nettype wire

// File: rtl/rca_acc.sv
// ============================================================================
// Module      : rca_acc
// Description : CW-bit ripple-carry adder of 3:2 cells, carry-in tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rca_acc #(
    parameter int CW = 5
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    output logic [CW-1:0] sum
);

    logic [CW-1:0] w_carry;

    assign w_carry[0] = 1'b0;

    // The running total never exceeds WIDTH, so the MSB carry-out is dropped
    for (genvar i = 0; i < CW; i++) begin : g_bit
        if (i < CW - 1) begin : g_cell
            counter_3_2 u_cell (
                .a     (a[i]),
                .b     (b[i]),
                .c     (w_carry[i]),
                .sum   (sum[i]),
                .carry (w_carry[i+1])
            );
        end else begin : g_msb
            assign sum[i] = a[i] ^ b[i] ^ w_carry[i];
        end
    end

endmodule

`default_nettype wire

// File: rtl/popcount_seq.sv
// ============================================================================
// Module      : popcount_seq
// Description : Iterative popcount, one 7-bit chunk per cycle via counter_7_3.
//               Optional macro POPCOUNT_EARLY_EXIT_EN ends counting once the
//               remaining chunks are all zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module popcount_seq
    import popcount_pkg::*;
#(
    parameter int WIDTH = 28
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [WIDTH-1:0]                   in_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [popcount_pkg::calc_cw(WIDTH)-1:0] out_count
);

    localparam int NCHUNK = calc_nchunk(WIDTH);
    localparam int CW     = calc_cw(WIDTH);
    localparam int SRW    = NCHUNK * CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    state_t          r_state;
    state_t          w_state_next;
    logic [SRW-1:0]  r_sr;
    logic [SRW-1:0]  w_sr_shift;
    logic [CW-1:0]   r_acc;
    logic [IW-1:0]   r_idx;
    logic [2:0]      w_part;
    logic [CW-1:0]   w_part_ext;
    logic [CW-1:0]   w_sum;
    logic            w_last;

    counter_7_3 u_cnt (
        .x   (r_sr[CHUNK-1:0]),
        .cnt (w_part)
    );

    assign w_part_ext = CW'(w_part);

    rca_acc #(
        .CW (CW)
    ) u_acc (
        .a   (r_acc),
        .b   (w_part_ext),
        .sum (w_sum)
    );

    assign w_sr_shift = r_sr >> CHUNK;

`ifdef POPCOUNT_EARLY_EXIT_EN
    assign w_last = (r_idx == IW'(NCHUNK - 1)) || (w_sr_shift == '0);
`else
    assign w_last = (r_idx == IW'(NCHUNK - 1));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_sr    <= '0;
            r_acc   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_sr  <= SRW'(in_data);
                        r_acc <= '0;
                        r_idx <= '0;
                    end
                end
                ST_COUNT: begin
                    r_acc <= w_sum;
                    r_sr  <= w_sr_shift;
                    r_idx <= r_idx + IW'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (in_valid)  w_state_next = ST_COUNT;
            ST_COUNT: if (w_last)    w_state_next = ST_DONE;
            ST_DONE:  if (out_ready) w_state_next = ST_IDLE;
            default:                 w_state_next = ST_IDLE;
        endcase
    end

    // rst gates in_ready directly so no word is offered while reset is held
    assign in_ready  = !rst && (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign out_count = r_acc;

endmodule

`default_nettype wire
